// File: rtl/kempston_mouse_if.sv
// CPU-side I/O read bus between the Z80 bus decoder and the Kempston mouse port.
interface kempston_mouse_if;
  logic        en;
  logic [15:0] a;
  logic        iord;
  logic [7:0]  d_out;
  logic        d_out_active;

  modport master (output en, output a, output iord, input d_out, input d_out_active);
  modport slave  (input en, input a, input iord, output d_out, output d_out_active);
endinterface

// File: rtl/kempston_mouse.sv
// PS/2 mouse front-end: enables streaming with 0xF4, assembles 3-byte movement
// packets into wrapping X/Y positions and buttons, and serves the Kempston ports.
module kempston_mouse #(
  parameter int CLK_FREQ     = 28_000_000,
  parameter int INHIBIT_US   = 120,
  parameter int TIMEOUT_US   = 2000,
  parameter int INIT_WAIT_MS = 600
) (
  input  logic clk28,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic ps2_clk_oe,
  output logic ps2_dat_oe,
  output logic ready,
  kempston_mouse_if.slave bus
);

  // Timer lengths in clk28 cycles; split as kHz * us / 1000 to stay inside 32 bits.
  localparam int CYC_PER_MS = CLK_FREQ / 1000;
  localparam int INIT_CYC   = CYC_PER_MS * INIT_WAIT_MS;
  localparam int INH_CYC    = (CYC_PER_MS * INHIBIT_US) / 1000;
  localparam int TMO_CYC    = (CYC_PER_MS * TIMEOUT_US) / 1000;
  localparam logic [31:0] INIT_LAST = 32'(((INIT_CYC > 1) ? INIT_CYC : 1) - 1);
  localparam logic [31:0] INH_LAST  = 32'(((INH_CYC  > 1) ? INH_CYC  : 1) - 1);
  localparam logic [31:0] TMO_LAST  = 32'(((TMO_CYC  > 1) ? TMO_CYC  : 1) - 1);
  localparam logic [7:0]  CMD_ENABLE = 8'hF4;
  localparam logic [7:0]  RSP_ACK    = 8'hFA;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_TX      = 3'd2,
    ST_TX_ACK  = 3'd3,
    ST_RX_ACK  = 3'd4,
    ST_STREAM  = 3'd5
  } state_t;

  // Odd parity bit: makes the total count of ones across data and parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

  state_t      state_r, state_nxt;
  logic [1:0]  clk_sync_r, dat_sync_r;
  logic [7:0]  clk_hist_r, dat_hist_r;
  logic        clk_filt_r, dat_filt_r, clk_filt_d_r;
  logic [31:0] delay_cnt_r, wdog_cnt_r;
  logic [9:0]  tx_sr_r;
  logic [3:0]  tx_cnt_r;
  logic        tx_low_r;
  logic [9:0]  rx_sr_r;
  logic [3:0]  rx_cnt_r;
  logic [1:0]  pkt_idx_r;
  logic [7:0]  b0_r, b1_r, x_r, y_r;
  logic [2:0]  btn_r;   // {middle, left, right}, 1 = pressed
  logic        clk_oe_s, dat_oe_s, ready_s;
  logic        fall_s, wait_done_s, inhibit_last_s, wdog_active_s, timeout_s;
  logic        rx_en_s, rx_done_s, rx_good_s;
  logic [7:0]  rx_byte_s;
  logic        unused_s;

  assign fall_s         = clk_filt_d_r & ~clk_filt_r;
  assign wait_done_s    = (state_r == ST_WAIT) && (delay_cnt_r == INIT_LAST);
  assign inhibit_last_s = (state_r == ST_INHIBIT) && (delay_cnt_r == INH_LAST);
  assign wdog_active_s  = (state_r == ST_TX) || (state_r == ST_TX_ACK) || (state_r == ST_RX_ACK) ||
                          ((state_r == ST_STREAM) && (rx_cnt_r != 4'd0));
  assign timeout_s      = wdog_active_s && (wdog_cnt_r == TMO_LAST);
  assign rx_en_s        = (state_r == ST_RX_ACK) || (state_r == ST_STREAM);
  assign rx_done_s      = rx_en_s && fall_s && (rx_cnt_r == 4'd10);
  assign rx_byte_s      = rx_sr_r[8:1];
  assign rx_good_s      = ~rx_sr_r[0] & dat_filt_r & (odd_parity(rx_byte_s) == rx_sr_r[9]);
  assign unused_s       = ^{bus.a[15:11], b0_r[5:3]};

  // Two-flop synchroniser followed by an 8-equal-sample glitch filter on each line.
  always_ff @(posedge clk28) begin
    if (rst) begin
      clk_sync_r   <= 2'b11;
      dat_sync_r   <= 2'b11;
      clk_hist_r   <= 8'hFF;
      dat_hist_r   <= 8'hFF;
      clk_filt_r   <= 1'b1;
      dat_filt_r   <= 1'b1;
      clk_filt_d_r <= 1'b1;
    end else begin
      clk_sync_r   <= {clk_sync_r[0], ps2_clk_in};
      dat_sync_r   <= {dat_sync_r[0], ps2_dat_in};
      clk_hist_r   <= {clk_hist_r[6:0], clk_sync_r[1]};
      dat_hist_r   <= {dat_hist_r[6:0], dat_sync_r[1]};
      clk_filt_r   <= (&clk_hist_r) ? 1'b1 : ((~|clk_hist_r) ? 1'b0 : clk_filt_r);
      dat_filt_r   <= (&dat_hist_r) ? 1'b1 : ((~|dat_hist_r) ? 1'b0 : dat_filt_r);
      clk_filt_d_r <= clk_filt_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk28) begin
    if (rst) state_r <= ST_WAIT;
    else     state_r <= state_nxt;
  end

  // FSM next-state logic: init handshake, then stream forever.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_WAIT:    if (wait_done_s) state_nxt = ST_INHIBIT; else state_nxt = state_r;
      ST_INHIBIT: if (inhibit_last_s) state_nxt = ST_TX; else state_nxt = state_r;
      ST_TX: begin
        if (timeout_s) state_nxt = ST_WAIT;
        else if (fall_s && (tx_cnt_r == 4'd9)) state_nxt = ST_TX_ACK;
        else state_nxt = state_r;
      end
      ST_TX_ACK: begin
        if (timeout_s) state_nxt = ST_WAIT;
        else if (fall_s) state_nxt = dat_filt_r ? ST_WAIT : ST_RX_ACK;
        else state_nxt = state_r;
      end
      ST_RX_ACK: begin
        if (timeout_s) state_nxt = ST_WAIT;
        else if (rx_done_s) state_nxt = (rx_good_s && (rx_byte_s == RSP_ACK)) ? ST_STREAM : ST_WAIT;
        else state_nxt = state_r;
      end
      ST_STREAM: state_nxt = ST_STREAM;
      default:   state_nxt = ST_WAIT;
    endcase
  end

  // FSM output decode: clock inhibit, data pull-down and ready flag.
  always_comb begin
    clk_oe_s = 1'b0;
    dat_oe_s = 1'b0;
    ready_s  = 1'b0;
    case (state_r)
      ST_INHIBIT: begin
        clk_oe_s = 1'b1;
        dat_oe_s = inhibit_last_s;
      end
      ST_TX:     dat_oe_s = tx_low_r;
      ST_STREAM: ready_s  = 1'b1;
      default: begin
        clk_oe_s = 1'b0;
        dat_oe_s = 1'b0;
        ready_s  = 1'b0;
      end
    endcase
  end

  // Registered line drivers and ready flag.
  always_ff @(posedge clk28) begin
    if (rst) begin
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      ready      <= 1'b0;
    end else begin
      ps2_clk_oe <= clk_oe_s;
      ps2_dat_oe <= dat_oe_s;
      ready      <= ready_s;
    end
  end

  // Init-wait / inhibit duration counter, restarted on every state change.
  always_ff @(posedge clk28) begin
    if (rst || (state_nxt != state_r)) delay_cnt_r <= 32'd0;
    else if ((state_r == ST_WAIT) || (state_r == ST_INHIBIT)) delay_cnt_r <= delay_cnt_r + 32'd1;
    else delay_cnt_r <= 32'd0;
  end

  // Watchdog: cycles since the last device clock fall while a transfer is pending.
  always_ff @(posedge clk28) begin
    if (rst || !wdog_active_s || fall_s || timeout_s) wdog_cnt_r <= 32'd0;
    else wdog_cnt_r <= wdog_cnt_r + 32'd1;
  end

  // Host transmit shifter: start bit at end of inhibit, then data, parity, stop.
  always_ff @(posedge clk28) begin
    if (rst) begin
      tx_sr_r  <= 10'd0;
      tx_cnt_r <= 4'd0;
      tx_low_r <= 1'b0;
    end else if (state_r == ST_WAIT) begin
      tx_sr_r  <= {1'b1, odd_parity(CMD_ENABLE), CMD_ENABLE};
      tx_cnt_r <= 4'd0;
      tx_low_r <= 1'b0;
    end else if (inhibit_last_s) begin
      tx_low_r <= 1'b1;
    end else if ((state_r == ST_TX) && fall_s) begin
      tx_low_r <= ~tx_sr_r[0];
      tx_sr_r  <= {1'b1, tx_sr_r[9:1]};
      tx_cnt_r <= tx_cnt_r + 4'd1;
    end else begin
      tx_low_r <= tx_low_r;
    end
  end

  // Device receive shifter: 11 bits per frame, sampled on clock falls.
  always_ff @(posedge clk28) begin
    if (rst || !rx_en_s || timeout_s) begin
      rx_cnt_r <= 4'd0;
    end else if (fall_s) begin
      if (rx_cnt_r == 4'd10) begin
        rx_cnt_r <= 4'd0;
      end else begin
        rx_cnt_r <= rx_cnt_r + 4'd1;
        rx_sr_r  <= {dat_filt_r, rx_sr_r[9:1]};
      end
    end else begin
      rx_cnt_r <= rx_cnt_r;
    end
  end

  // Packet assembly; the whole position/button update lands on byte 2.
  always_ff @(posedge clk28) begin
    if (rst) begin
      pkt_idx_r <= 2'd0;
      b0_r      <= 8'd0;
      b1_r      <= 8'd0;
      x_r       <= 8'd0;
      y_r       <= 8'd0;
      btn_r     <= 3'b000;
    end else if (state_r != ST_STREAM || timeout_s) begin
      pkt_idx_r <= 2'd0;
    end else if (rx_done_s) begin
      if (!rx_good_s) begin
        pkt_idx_r <= 2'd0;
      end else begin
        case (pkt_idx_r)
          2'd0: if (rx_byte_s[3]) begin b0_r <= rx_byte_s; pkt_idx_r <= 2'd1; end
          2'd1: begin b1_r <= rx_byte_s; pkt_idx_r <= 2'd2; end
          2'd2: begin
            btn_r     <= {b0_r[2], b0_r[0], b0_r[1]};
            x_r       <= b0_r[6] ? x_r : x_r + b1_r;
            y_r       <= b0_r[7] ? y_r : y_r + rx_byte_s;
            pkt_idx_r <= 2'd0;
          end
          default: pkt_idx_r <= 2'd0;
        endcase
      end
    end else begin
      pkt_idx_r <= pkt_idx_r;
    end
  end

  // Kempston port decode on the registered position and button state.
  always_comb begin
    bus.d_out        = 8'hFF;
    bus.d_out_active = 1'b0;
    if (bus.en && bus.iord && (bus.a[7:0] == 8'hDF)) begin
      case (bus.a[10:8])
        3'b011: begin bus.d_out = x_r; bus.d_out_active = 1'b1; end
        3'b111: begin bus.d_out = y_r; bus.d_out_active = 1'b1; end
        3'b010: begin bus.d_out = {5'b11111, ~btn_r}; bus.d_out_active = 1'b1; end
        default: begin bus.d_out = 8'hFF; bus.d_out_active = 1'b0; end
      endcase
    end else begin
      bus.d_out        = 8'hFF;
      bus.d_out_active = 1'b0;
    end
  end

endmodule

// File: tb/tb_kempston_mouse.sv
// Bench for kempston_mouse: a PS/2 mouse model on open-drain lines, a reference
// position model, and a read scoreboard checked against the Kempston ports.
`timescale 1ns/1ps
module tb_kempston_mouse;
  localparam int H = 25;   // PS/2 half clock period in clk28 cycles

  typedef struct packed { logic act; logic [7:0] d; } rd_t;

  logic clk28 = 1'b0;
  logic rst   = 1'b1;
  logic model_clk = 1'b1;
  logic model_dat = 1'b1;
  logic ps2_clk_oe, ps2_dat_oe, ready;
  wire  ps2_clk_in = model_clk & ~ps2_clk_oe;
  wire  ps2_dat_in = model_dat & ~ps2_dat_oe;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mx = 8'd0, my = 8'd0;
  logic [2:0] mbtn = 3'b000;
  rd_t        exp_q[$];
  logic [7:0] cmd_q[$];

  kempston_mouse_if bus ();

  kempston_mouse #(.CLK_FREQ(1_000_000), .INHIBIT_US(20), .TIMEOUT_US(200), .INIT_WAIT_MS(1)) dut (
    .clk28(clk28), .rst(rst), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .ready(ready), .bus(bus));

  always #5 clk28 = ~clk28;

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation still running at 5 ms, expected completion");
    $fatal(1, "global timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk28);
  endtask

  function automatic rd_t model_read(input logic [15:0] addr, input logic e, input logic rd);
    rd_t r;
    r.act = 1'b0;
    r.d   = 8'hFF;
    if (e && rd && addr[7:0] == 8'hDF) begin
      case (addr[10:8])
        3'b011:  begin r.act = 1'b1; r.d = mx; end
        3'b111:  begin r.act = 1'b1; r.d = my; end
        3'b010:  begin r.act = 1'b1; r.d = {5'b11111, ~mbtn}; end
        default: r.act = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic do_read(input string name, input logic [15:0] addr, input logic e, input logic rd);
    rd_t got, exp;
    exp_q.push_back(model_read(addr, e, rd));
    @(posedge clk28); #1;
    bus.en = e; bus.a = addr; bus.iord = rd;
    @(negedge clk28);
    got = {bus.d_out_active, bus.d_out};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got active=%b d_out=%02h, expected active=%b d_out=%02h",
               name, got.act, got.d, exp.act, exp.d);
    end
    bus.iord = 1'b0;
    bus.en   = 1'b1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic dev_bit(input logic b);
    model_dat = b;
    wait_cyc(H); model_clk = 1'b0;
    wait_cyc(H); model_clk = 1'b1;
  endtask

  task automatic dev_send_byte(input logic [7:0] b, input logic bad_par);
    dev_bit(1'b0);
    for (int i = 0; i < 8; i++) dev_bit(b[i]);
    dev_bit(~(^b) ^ bad_par);
    dev_bit(1'b1);
    model_dat = 1'b1;
    wait_cyc(H);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    dev_send_byte(b0, 1'b0);
    dev_send_byte(b1, 1'b0);
    dev_send_byte(b2, 1'b0);
    mbtn = {b0[2], b0[0], b0[1]};
    if (!b0[6]) mx = mx + b1;
    if (!b0[7]) my = my + b2;
    wait_cyc(10);
  endtask

  // Mouse side of a host-to-device transfer, ending with the ACK pulse.
  task automatic dev_get_cmd(input string name, output int waited);
    logic [9:0] bits;
    logic [7:0] exp;
    int n;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 5000) begin wait_cyc(1); n++; end
    waited = n;
    n_checks++;
    if (ps2_clk_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_inhibit: ps2_clk_oe=%b after %0d cycles, expected 1", name, ps2_clk_oe, n);
      return;
    end
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 1000) begin wait_cyc(1); n++; end
    wait_cyc(30); #1;
    check_bit({name, "_start"}, ps2_dat_in, 1'b0);
    for (int i = 0; i < 10; i++) begin
      wait_cyc(H); model_clk = 1'b0;
      wait_cyc(H); model_clk = 1'b1;
      #1 bits[i] = ps2_dat_in;
    end
    model_dat = 1'b0;
    wait_cyc(H); model_clk = 1'b0;
    wait_cyc(H); model_clk = 1'b1;
    model_dat = 1'b1;
    exp = cmd_q.pop_front();
    n_checks++;
    if (bits[7:0] !== exp) begin
      n_fail++;
      $display("FAIL %s_data: got %02h, expected %02h", name, bits[7:0], exp);
    end
    check_bit({name, "_parity"}, bits[8], ~(^exp));
    check_bit({name, "_stop"}, bits[9], 1'b1);
  endtask

  task automatic check_wait(input string name, input int w);
    n_checks++;
    if (w < 900 || w > 1100) begin
      n_fail++;
      $display("FAIL %s: got %0d cycles before inhibit, expected 900..1100", name, w);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cyc(5);
    @(negedge clk28);
    check_bit("reset_clk_oe", ps2_clk_oe, 1'b0);
    check_bit("reset_dat_oe", ps2_dat_oe, 1'b0);
    check_bit("reset_ready", ready, 1'b0);
    do_read("reset_x", 16'hFBDF, 1'b1, 1'b1);
    do_read("reset_y", 16'hFFDF, 1'b1, 1'b1);
    do_read("reset_btn", 16'hFADF, 1'b1, 1'b1);
    @(posedge clk28); #1 rst = 1'b0;
  endtask

  task automatic test_init_nak;
    int w;
    cmd_q.push_back(8'hF4);
    dev_get_cmd("init1", w);
    check_wait("init1_wait", w);
    wait_cyc(40);
    dev_send_byte(8'hFE, 1'b0);
    wait_cyc(20); #1;
    check_bit("nak_ready", ready, 1'b0);
    cmd_q.push_back(8'hF4);
    dev_get_cmd("retry", w);
    check_wait("retry_wait", w);
  endtask

  task automatic test_init_ack;
    wait_cyc(40);
    dev_send_byte(8'hFA, 1'b0);
    wait_cyc(20); #1;
    check_bit("ack_ready", ready, 1'b1);
  endtask

  task automatic test_packet;
    send_pkt(8'h08, 8'h05, 8'hFD);
    do_read("pkt_x", 16'hFBDF, 1'b1, 1'b1);
    do_read("pkt_y", 16'hFFDF, 1'b1, 1'b1);
    do_read("pkt_btn", 16'hFADF, 1'b1, 1'b1);
  endtask

  task automatic test_buttons;
    send_pkt(8'h09, 8'h00, 8'h00);
    do_read("btn_left", 16'hFADF, 1'b1, 1'b1);
    send_pkt(8'h4C, 8'h10, 8'h01);
    do_read("xovf_x", 16'hFBDF, 1'b1, 1'b1);
    do_read("xovf_y", 16'hFFDF, 1'b1, 1'b1);
    do_read("xovf_btn", 16'hFADF, 1'b1, 1'b1);
  endtask

  task automatic test_resync;
    dev_send_byte(8'h00, 1'b0);
    send_pkt(8'h08, 8'h01, 8'h01);
    do_read("resync_x", 16'hFBDF, 1'b1, 1'b1);
    do_read("resync_y", 16'hFFDF, 1'b1, 1'b1);
    dev_send_byte(8'h08, 1'b0);
    dev_send_byte(8'h07, 1'b1);
    send_pkt(8'h08, 8'h02, 8'h02);
    do_read("parerr_x", 16'hFBDF, 1'b1, 1'b1);
    do_read("parerr_y", 16'hFFDF, 1'b1, 1'b1);
    dev_send_byte(8'h08, 1'b0);
    dev_bit(1'b0); dev_bit(1'b1); dev_bit(1'b0);
    model_dat = 1'b1;
    wait_cyc(300);
    send_pkt(8'h08, 8'h03, 8'h03);
    do_read("stall_x", 16'hFBDF, 1'b1, 1'b1);
    do_read("stall_y", 16'hFFDF, 1'b1, 1'b1);
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    d = 8'hFF - mx;
    send_pkt(8'h08, d, 8'h00);
    do_read("wrap_pre_x", 16'hFBDF, 1'b1, 1'b1);
    send_pkt(8'h08, 8'h02, 8'h00);
    do_read("wrap_x", 16'hFBDF, 1'b1, 1'b1);
  endtask

  task automatic test_decode;
    do_read("en_off", 16'hFBDF, 1'b0, 1'b1);
    do_read("iord_off", 16'hFBDF, 1'b1, 1'b0);
    do_read("low_byte_miss", 16'hFBDE, 1'b1, 1'b1);
    do_read("high_bits_miss", 16'hF8DF, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_tx;
    int n;
    rst = 1'b1;
    wait_cyc(3);
    #1 rst = 1'b0;
    mx = 8'd0; my = 8'd0; mbtn = 3'b000;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 3000) begin wait_cyc(1); n++; end
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 1000) begin wait_cyc(1); n++; end
    wait_cyc(30);
    wait_cyc(H); model_clk = 1'b0;
    wait_cyc(H); model_clk = 1'b1;
    wait_cyc(5); #1;
    check_bit("midtx_pre_dat_oe", ps2_dat_oe, 1'b1);
    @(posedge clk28); #1 rst = 1'b1;
    @(posedge clk28); #1;
    check_bit("midtx_clk_oe", ps2_clk_oe, 1'b0);
    check_bit("midtx_dat_oe", ps2_dat_oe, 1'b0);
    check_bit("midtx_ready", ready, 1'b0);
    do_read("midtx_x", 16'hFBDF, 1'b1, 1'b1);
    do_read("midtx_y", 16'hFFDF, 1'b1, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    bus.en = 1'b1; bus.a = 16'h0000; bus.iord = 1'b0;
    test_reset();
    test_init_nak();
    test_init_ack();
    test_packet();
    test_buttons();
    test_resync();
    test_wrap();
    test_decode();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
